// File: rtl/alu_issue_queue.sv
// Command FIFO and result stage in front of the 8-bit combinational ALU.
// Queues {func, a, b, use_acc}, issues the head each cycle, and registers the ALU result with an error flag.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [3:0]    i_cmd_func,
    input  logic [7:0]    i_cmd_a,
    input  logic [7:0]    i_cmd_b,
    input  logic          i_cmd_use_acc,
    output logic [7:0]    o_alu_a,
    output logic [7:0]    o_alu_b,
    output logic [3:0]    o_alu_func,
    input  logic [7:0]    i_alu_result,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [7:0]    o_res_data,
    output logic [3:0]    o_res_func,
    output logic          o_res_err,
    output logic [CW-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    mem_func    [DEPTH];
    logic [7:0]    mem_a       [DEPTH];
    logic [7:0]    mem_b       [DEPTH];
    logic          mem_use_acc [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    acc;

    logic          push;
    logic          issue;
    logic          empty;
    logic [3:0]    head_func;
    logic [7:0]    head_b;
    logic [7:0]    eff_a;

    function automatic logic calc_err(input logic [3:0] func,
                                      input logic [7:0] a,
                                      input logic [7:0] b);
        logic [8:0] sum;
        logic       err;
        sum = {1'b0, a} + {1'b0, b};
        err = 1'b0;
        case (func)
            4'b0010: err = sum[8];
            4'b0011: err = (a < b);
            default: err = 1'b0;
        endcase
        return err;
    endfunction

    // Ready looks only at registered occupancy, never at the output-stage handshake.
    assign o_cmd_ready = (count < CW'(DEPTH)) && !i_rst;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign empty       = (count == '0);
    assign issue       = !empty && (!o_res_valid || i_res_ready);

    assign head_func = mem_func[rd_ptr];
    assign head_b    = mem_b[rd_ptr];
    assign eff_a     = mem_use_acc[rd_ptr] ? acc : mem_a[rd_ptr];

    assign o_alu_a    = empty ? 8'h00 : eff_a;
    assign o_alu_b    = empty ? 8'h00 : head_b;
    assign o_alu_func = empty ? 4'h0  : head_func;
    assign o_count    = count;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_func[wr_ptr]    <= i_cmd_func;
            mem_a[wr_ptr]       <= i_cmd_a;
            mem_b[wr_ptr]       <= i_cmd_b;
            mem_use_acc[wr_ptr] <= i_cmd_use_acc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(issue);
        end
    end

    // Result stage: acc tracks the last issued result, independent of consumption.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc         <= 8'h00;
            o_res_valid <= 1'b0;
            o_res_data  <= 8'h00;
            o_res_func  <= 4'h0;
            o_res_err   <= 1'b0;
        end else if (issue) begin
            acc         <= i_alu_result;
            o_res_valid <= 1'b1;
            o_res_data  <= i_alu_result;
            o_res_func  <= head_func;
            o_res_err   <= calc_err(head_func, eff_a, head_b);
        end else if (o_res_valid && i_res_ready) begin
            o_res_valid <= 1'b0;
        end
    end

endmodule
